// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP instruction format, widths and opcodes
package dsp_pkg;

  localparam int OPCODE_WIDTH      = 6;
  localparam int SAMPLE_ADDR_WIDTH = 10;
  localparam int PARAM_ADDR_WIDTH  = 10;
  localparam int INSTR_WIDTH       = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH;
  localparam int PROG_ADDR_WIDTH   = 10;
  localparam int PIPE_DEPTH        = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    NOP    = 6'h00,
    MUL    = 6'h01,
    MAC    = 6'h02,
    ROTMAC = 6'h03,
    STORE  = 6'h04,
    IN     = 6'h05,
    OUT    = 6'h06
  } opcode_t;

  typedef struct packed {
    opcode_t                      opcode;
    logic [SAMPLE_ADDR_WIDTH-1:0] sample_addr;
    logic [PARAM_ADDR_WIDTH-1:0]  param_addr;
  } instr_t;

  localparam instr_t NOP_INSTR = '{opcode: NOP, sample_addr: '0, param_addr: '0};

endpackage

// File: rtl/dsp_sequencer.sv
// rtl/dsp_sequencer.sv - per-frame instruction sequencer feeding the DSP core
module dsp_sequencer
  import dsp_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_last_addr,
  output logic [PROG_ADDR_WIDTH-1:0] imem_rd_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_rd_data,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  input  logic                       overrun_clear
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  seq_state_t                 r_state;
  seq_state_t                 w_state_next;
  logic [PROG_ADDR_WIDTH-1:0] r_pc;
  logic [PROG_ADDR_WIDTH-1:0] w_pc_next;
  logic [PROG_ADDR_WIDTH-1:0] r_last;
  logic [PROG_ADDR_WIDTH-1:0] w_last_next;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           w_cnt_next;
  logic                       r_fetch_valid;
  logic                       r_frame_done;
  logic                       w_frame_done_next;
  logic                       r_overrun;
  logic                       w_busy;

  assign w_busy = (r_state != ST_IDLE);

  // State, pc, drain counter and flag registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_last        <= '0;
      r_cnt         <= '0;
      r_fetch_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_last        <= w_last_next;
      r_cnt         <= w_cnt_next;
      // Memory data for the address issued in a RUN cycle arrives one cycle later
      r_fetch_valid <= (r_state == ST_RUN);
      r_frame_done  <= w_frame_done_next;
      // A new overrun event takes priority over a simultaneous clear
      if (frame_start && w_busy)
        r_overrun <= 1'b1;
      else if (overrun_clear)
        r_overrun <= 1'b0;
    end
  end

  // Next-state logic: fetch 0..last, then count out the core pipeline before signalling done
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_last_next       = r_last;
    w_cnt_next        = r_cnt;
    w_frame_done_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_next = '0;
        if (frame_start) begin
          w_last_next  = prog_last_addr;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Exit on the last address rather than wrapping so a full-memory program ends cleanly
        if (r_pc == r_last) begin
          w_state_next = ST_DRAIN;
          w_cnt_next   = CNT_W'(PIPE_DEPTH);
        end else begin
          w_pc_next = r_pc + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_next      = ST_IDLE;
          w_pc_next         = '0;
          w_frame_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_pc_next    = '0;
      end
    endcase
  end

  assign imem_rd_addr = r_pc;
  assign instruction  = r_fetch_valid ? imem_rd_data : NOP_INSTR;
  assign busy         = w_busy;
  assign frame_done   = r_frame_done;
  assign overrun      = r_overrun;

endmodule

// File: doc/dsp_sequencer.md
Name: dsp_sequencer

Overview:
Instruction sequencer directly upstream of the DSP core's `instruction` input. Once per audio sample frame it walks a program held in synchronous instruction memory from address 0 to a programmable last address. It presents one instruction per cycle, and NOP (all-zero) whenever no program is running. After the last instruction it waits for the core pipeline to drain, then pulses frame_done so the IO side can swap sample buffers.

Parameters:
OPCODE_WIDTH, 6, opcode field width
SAMPLE_ADDR_WIDTH, 10, sample address field width
PARAM_ADDR_WIDTH, 10, param address field width
INSTR_WIDTH, OPCODE_WIDTH+SAMPLE_ADDR_WIDTH+PARAM_ADDR_WIDTH, instruction word width (26)
PROG_ADDR_WIDTH, 10, instruction memory address width
PIPE_DEPTH, 4, core stages after decode (read, ex1, ex2, writeback)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock, synchronous, active-low
frame_start  in  1  single-cycle pulse from audio IO: start a frame
prog_last_addr  in  PROG_ADDR_WIDTH  address of the final program instruction; latched at frame accept
imem_rd_addr  out  PROG_ADDR_WIDTH  instruction memory read address
imem_rd_data  in  INSTR_WIDTH  instruction memory data; valid one cycle after address
instruction  out  INSTR_WIDTH  to DSP core; all-zero (NOP) when not fetching
busy  out  1  high from frame accept until frame_done
frame_done  out  1  one-cycle pulse: last instruction has cleared core writeback
overrun  out  1  sticky: frame_start arrived while busy
overrun_clear  in  1  clears overrun

Behaviour:
- Reset (reset_n low at a clk edge):
  - state IDLE, pc 0, fetch_valid 0, drain counter 0.
  - Outputs: imem_rd_addr 0, instruction 0, busy 0, frame_done 0, overrun 0.
  - Reset mid-frame aborts immediately; instruction is NOP from the first cycle after the reset edge.
- States: IDLE, RUN, DRAIN.
- imem_rd_addr is driven from the pc register.
- fetch_valid is a register: 1 iff the previous cycle was RUN.
- instruction = fetch_valid ? imem_rd_data : 0 (combinational from memory data and flag).
- IDLE: pc held at 0. A frame_start sampled high → latch prog_last_addr into last_q, go to RUN.
- RUN: each cycle pc++ .
  - In the cycle where pc == last_q: go to DRAIN, load drain counter with PIPE_DEPTH, hold pc.
- DRAIN: counter decrements each cycle.
  - At 0: return to IDLE, set pc to 0, register frame_done high for exactly one cycle.
- Timing, with frame_start high in cycle 0 and L = prog_last_addr:
  - Addresses 0..L presented in cycles 1..L+1.
  - Instructions 0..L appear on instruction in cycles 2..L+2.
  - frame_done is high in cycle L+7 (defaults); busy is high in cycles 1..L+6.
  - A frame therefore occupies L+7 cycles.
- busy = (state != IDLE).
- L = 0 is legal: one instruction executes.
- pc never wraps: RUN exits at last_q. L = 2^PROG_ADDR_WIDTH−1 executes the full memory.
- prog_last_addr changes while busy are ignored.
- frame_start while busy is ignored (the running frame completes unchanged) and sets overrun.
- frame_start in the same cycle frame_done is high is accepted (state is already IDLE).
- overrun_clear and a new overrun event in the same cycle: the set wins.
- frame_done and busy never assert together.

Decomposition:
- Shared package dsp_pkg holds:
  - opcode_t enum (NOP 0x00, MUL 0x01, MAC 0x02, ROTMAC 0x03, STORE 0x04, IN 0x05, OUT 0x06);
  - instr_t packed struct {opcode, sample_addr, param_addr};
  - the width constants;
  - the NOP_INSTR constant.
- The DSP core imports the same package.
- A single module with no sub-modules; the state machine and counters are too small to split.

Test Plan:
- Reset, then idle for 20 cycles → instruction 0, imem_rd_addr 0, busy/frame_done/overrun 0 throughout.
- imem holds 0x1000000+k at address k, L=3, frame_start in cycle 0 → instruction = 0x1000000..0x1000003 in cycles 2..5; 0 in cycles 6+; busy high in cycles 1..9; frame_done high in cycle 10 only.
- L=0, frame_start in cycle 0 → exactly one non-NOP instruction, in cycle 2; frame_done in cycle 7.
- L=5, second frame_start in cycle 3 → first frame completes unchanged (frame_done in cycle 12); overrun=1 from cycle 4. overrun_clear together with a further mid-frame frame_start → overrun stays 1.
- frame_start asserted exactly in the frame_done cycle, L=2 → second frame accepted; its address 0 appears in the next cycle.
- L=8, reset_n low in cycle 5 → from cycle 6, instruction 0 and busy 0; frame_done never pulses; after release a fresh frame_start runs normally from address 0.
